alu_reservation_station: RTL

Holds dispatched integer/branch instructions until both source operands are available, then issues one per cycle to the ALU. Sits between the dispatch/rename stage and the ALU. It captures operand values from two result broadcast buses (ALU and load/store unit) and drives the ALU's registered instruction inputs. Entries are tagged by their 3-bit reorder-buffer id.

---
 rtl/alu_reservation_station.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//
// Holds dispatched integer/branch instructions until both source operands are
// available, then issues at most one per cycle to the ALU. Operand values are
// captured from the ALU and load/store result broadcast buses. Each entry is
// tagged by its 3-bit reorder-buffer id.
//
// Ports
//   clk_in, rst_in            clock; asynchronous active-high reset
//   rdy_in                    global ready, low freezes the whole block
//   flush_pipline             mispredict flush, empties every entry
//   dispatch_*                instruction offered by dispatch/rename
//   alu_cdb_*, mem_cdb_*      result broadcast buses (valid/id/value)
//   rs_full                   no free entry (combinational)
//   have_ins                  issue strobe, one cycle per instruction
//   ins_id ... is_compressed_ins   registered issue fields to the ALU
// ---------------------------------------------------------------------------
module alu_reservation_station #(
  parameter int RS_SIZE = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,

  input  logic        dispatch_valid,
  input  logic [2:0]  dispatch_ins_id,
  input  logic [6:0]  dispatch_opcode,
  input  logic [2:0]  dispatch_funct3,
  input  logic [6:0]  dispatch_funct7,
  input  logic [31:0] dispatch_imm,
  input  logic [5:0]  dispatch_shamt,
  input  logic [31:0] dispatch_PC,
  input  logic        dispatch_is_compressed,
  input  logic [31:0] dispatch_rs1_val,
  input  logic [31:0] dispatch_rs2_val,
  input  logic        dispatch_rs1_rdy,
  input  logic        dispatch_rs2_rdy,
  input  logic [2:0]  dispatch_rs1_dep,
  input  logic [2:0]  dispatch_rs2_dep,

  input  logic        alu_cdb_valid,
  input  logic [2:0]  alu_cdb_id,
  input  logic [31:0] alu_cdb_val,
  input  logic        mem_cdb_valid,
  input  logic [2:0]  mem_cdb_id,
  input  logic [31:0] mem_cdb_val,

  output logic        rs_full,
  output logic        have_ins,
  output logic [2:0]  ins_id,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [31:0] imm_val,
  output logic [5:0]  shamt_val,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] request_PC,
  output logic        is_compressed_ins
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage
  logic [RS_SIZE-1:0] busy;
  logic [2:0]         ent_id     [RS_SIZE];
  logic [6:0]         ent_opcode [RS_SIZE];
  logic [2:0]         ent_funct3 [RS_SIZE];
  logic [6:0]         ent_funct7 [RS_SIZE];
  logic [31:0]        ent_imm    [RS_SIZE];
  logic [5:0]         ent_shamt  [RS_SIZE];
  logic [31:0]        ent_pc     [RS_SIZE];
  logic               ent_comp   [RS_SIZE];
  logic [RS_SIZE-1:0] ent_rs1_rdy;
  logic [RS_SIZE-1:0] ent_rs2_rdy;
  logic [2:0]         ent_rs1_dep [RS_SIZE];
  logic [2:0]         ent_rs2_dep [RS_SIZE];
  logic [31:0]        ent_rs1_val [RS_SIZE];
  logic [31:0]        ent_rs2_val [RS_SIZE];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_rs1_rdy;
  logic [31:0]      disp_rs1_val;
  logic             disp_rs2_rdy;
  logic [31:0]      disp_rs2_val;
  logic             do_dispatch;

  // Priority pick of the lowest free slot and the lowest ready entry; the
  // descending loop lets the lowest index win. Also resolves the same-cycle
  // broadcast bypass for the offered instruction's operands.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && ent_rs1_rdy[i] && ent_rs2_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    disp_rs1_rdy = dispatch_rs1_rdy;
    disp_rs1_val = dispatch_rs1_val;
    if (!dispatch_rs1_rdy) begin
      if (alu_cdb_valid && alu_cdb_id == dispatch_rs1_dep) begin
        disp_rs1_rdy = 1'b1;
        disp_rs1_val = alu_cdb_val;
      end else if (mem_cdb_valid && mem_cdb_id == dispatch_rs1_dep) begin
        disp_rs1_rdy = 1'b1;
        disp_rs1_val = mem_cdb_val;
      end
    end

    disp_rs2_rdy = dispatch_rs2_rdy;
    disp_rs2_val = dispatch_rs2_val;
    if (!dispatch_rs2_rdy) begin
      if (alu_cdb_valid && alu_cdb_id == dispatch_rs2_dep) begin
        disp_rs2_rdy = 1'b1;
        disp_rs2_val = alu_cdb_val;
      end else if (mem_cdb_valid && mem_cdb_id == dispatch_rs2_dep) begin
        disp_rs2_rdy = 1'b1;
        disp_rs2_val = mem_cdb_val;
      end
    end

    rs_full     = &busy;
    do_dispatch = dispatch_valid && free_found;
  end

  // Entry update, wake-up, issue and dispatch. The dispatch target is a slot
  // that was free at cycle start, so it never collides with wake-up writes or
  // with the slot being issued (a slot freed by issue is reusable next cycle).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy              <= '0;
      ent_rs1_rdy       <= '0;
      ent_rs2_rdy       <= '0;
      have_ins          <= 1'b0;
      ins_id            <= '0;
      rs1_val           <= '0;
      rs2_val           <= '0;
      imm_val           <= '0;
      shamt_val         <= '0;
      opcode            <= '0;
      funct3            <= '0;
      funct7            <= '0;
      request_PC        <= '0;
      is_compressed_ins <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_id[i]      <= '0;
        ent_opcode[i]  <= '0;
        ent_funct3[i]  <= '0;
        ent_funct7[i]  <= '0;
        ent_imm[i]     <= '0;
        ent_shamt[i]   <= '0;
        ent_pc[i]      <= '0;
        ent_comp[i]    <= 1'b0;
        ent_rs1_dep[i] <= '0;
        ent_rs2_dep[i] <= '0;
        ent_rs1_val[i] <= '0;
        ent_rs2_val[i] <= '0;
      end
    end else if (!rdy_in) begin
      have_ins <= 1'b0;
    end else if (flush_pipline) begin
      busy     <= '0;
      have_ins <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !ent_rs1_rdy[i]) begin
          if (alu_cdb_valid && alu_cdb_id == ent_rs1_dep[i]) begin
            ent_rs1_rdy[i] <= 1'b1;
            ent_rs1_val[i] <= alu_cdb_val;
          end else if (mem_cdb_valid && mem_cdb_id == ent_rs1_dep[i]) begin
            ent_rs1_rdy[i] <= 1'b1;
            ent_rs1_val[i] <= mem_cdb_val;
          end
        end
        if (busy[i] && !ent_rs2_rdy[i]) begin
          if (alu_cdb_valid && alu_cdb_id == ent_rs2_dep[i]) begin
            ent_rs2_rdy[i] <= 1'b1;
            ent_rs2_val[i] <= alu_cdb_val;
          end else if (mem_cdb_valid && mem_cdb_id == ent_rs2_dep[i]) begin
            ent_rs2_rdy[i] <= 1'b1;
            ent_rs2_val[i] <= mem_cdb_val;
          end
        end
      end

      if (sel_found) begin
        have_ins          <= 1'b1;
        busy[sel_idx]     <= 1'b0;
        ins_id            <= ent_id[sel_idx];
        rs1_val           <= ent_rs1_val[sel_idx];
        rs2_val           <= ent_rs2_val[sel_idx];
        imm_val           <= ent_imm[sel_idx];
        shamt_val         <= ent_shamt[sel_idx];
        opcode            <= ent_opcode[sel_idx];
        funct3            <= ent_funct3[sel_idx];
        funct7            <= ent_funct7[sel_idx];
        request_PC        <= ent_pc[sel_idx];
        is_compressed_ins <= ent_comp[sel_idx];
      end else begin
        have_ins <= 1'b0;
      end

      if (do_dispatch) begin
        busy[free_idx]        <= 1'b1;
        ent_id[free_idx]      <= dispatch_ins_id;
        ent_opcode[free_idx]  <= dispatch_opcode;
        ent_funct3[free_idx]  <= dispatch_funct3;
        ent_funct7[free_idx]  <= dispatch_funct7;
        ent_imm[free_idx]     <= dispatch_imm;
        ent_shamt[free_idx]   <= dispatch_shamt;
        ent_pc[free_idx]      <= dispatch_PC;
        ent_comp[free_idx]    <= dispatch_is_compressed;
        ent_rs1_rdy[free_idx] <= disp_rs1_rdy;
        ent_rs1_dep[free_idx] <= dispatch_rs1_dep;
        ent_rs1_val[free_idx] <= disp_rs1_val;
        ent_rs2_rdy[free_idx] <= disp_rs2_rdy;
        ent_rs2_dep[free_idx] <= dispatch_rs2_dep;
        ent_rs2_val[free_idx] <= disp_rs2_val;
      end
    end
  end

endmodule
